gru_state_update: RTL and testbench

Parametrised, pipelined fixed-point GRU hidden-state update engine with two modes. Forward mode computes h = z·h_prev + (1−z)·h_cand. Tangent mode computes dh = dz·(h_prev−h_cand) + z·dh_prev + (1−z)·dh_cand. It processes a CH-element hidden vector one element per cycle over a valid/ready stream, with round-to-nearest and saturation. It sits after the gate-activation stage in the GRU hidden layer and feeds the hidden-state buffer.

---
 rtl/gru_state_update_if.sv | 34 +++
 rtl/gru_state_update.sv | 226 ++++++++++++++++++++++
 tb/tb_gru_state_update.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gru_state_update_if.sv
// Stream interface for the GRU hidden-state update engine: operand input stream,
// result output stream and the sticky saturation flag controls.
interface gru_state_update_if #(
    parameter int DATABIT = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic                      mode_i;
    logic signed [DATABIT-1:0] z_i;
    logic signed [DATABIT-1:0] dz_i;
    logic signed [DATABIT-1:0] h_prev_i;
    logic signed [DATABIT-1:0] h_cand_i;
    logic signed [DATABIT-1:0] dh_prev_i;
    logic signed [DATABIT-1:0] dh_cand_i;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [DATABIT-1:0] h_o;
    logic                      out_last;
    logic                      out_mode;
    logic                      sat_flag;
    logic                      sat_clr;

    modport master (
        output in_valid, mode_i, z_i, dz_i, h_prev_i, h_cand_i, dh_prev_i, dh_cand_i,
        output out_ready, sat_clr,
        input  in_ready, out_valid, h_o, out_last, out_mode, sat_flag
    );

    modport slave (
        input  in_valid, mode_i, z_i, dz_i, h_prev_i, h_cand_i, dh_prev_i, dh_cand_i,
        input  out_ready, sat_clr,
        output in_ready, out_valid, h_o, out_last, out_mode, sat_flag
    );
endinterface

// File: rtl/gru_state_update.sv
// Pipelined fixed-point GRU hidden-state update, forward and tangent modes.
// S1 registers operands plus diff/omz, S2 registers the three products,
// S3 sums, rounds half up, clamps and lands in the output register.
module gru_state_update #(
    parameter int DATABIT = 16,
    parameter int FRAC    = 14,
    parameter int CH      = 32
) (
    input logic           clk,
    input logic           rst,
    gru_state_update_if.slave bus
);
    localparam int W1 = DATABIT + 1;
    localparam int WP = 2 * DATABIT + 2;
    localparam int WS = 2 * DATABIT + 4;
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic signed [W1-1:0] One  = W1'(1) <<< FRAC;
    localparam logic signed [WS-1:0] Half = WS'(1) <<< (FRAC - 1);
    localparam logic signed [WS-1:0] MaxV = (WS'(1) <<< (DATABIT - 1)) - WS'(1);
    localparam logic signed [WS-1:0] MinV = -(WS'(1) <<< (DATABIT - 1));
    localparam logic [CW-1:0]        LastCnt = CW'(CH - 1);

    // Control
    logic                      adv;
    logic                      hs;
    logic                      elem_mode;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      mode_q, mode_d;

    // Stage 1
    logic                      s1_valid_q, s1_valid_d;
    logic                      s1_last_q, s1_last_d;
    logic                      s1_mode_q, s1_mode_d;
    logic signed [DATABIT-1:0] s1_z_q, s1_z_d;
    logic signed [DATABIT-1:0] s1_dz_q, s1_dz_d;
    logic signed [DATABIT-1:0] s1_h_prev_q, s1_h_prev_d;
    logic signed [DATABIT-1:0] s1_h_cand_q, s1_h_cand_d;
    logic signed [DATABIT-1:0] s1_dh_prev_q, s1_dh_prev_d;
    logic signed [DATABIT-1:0] s1_dh_cand_q, s1_dh_cand_d;
    logic signed [W1-1:0]      s1_diff_q, s1_diff_d;
    logic signed [W1-1:0]      s1_omz_q, s1_omz_d;

    // Stage 2
    logic                      s2_valid_q, s2_valid_d;
    logic                      s2_last_q, s2_last_d;
    logic                      s2_mode_q, s2_mode_d;
    logic signed [WP-1:0]      s2_p1_q, s2_p1_d;
    logic signed [WP-1:0]      s2_p2_q, s2_p2_d;
    logic signed [WP-1:0]      s2_p3_q, s2_p3_d;

    // Stage 3 / output register
    logic signed [WS-1:0]      sum;
    logic signed [WS-1:0]      rnd;
    logic signed [DATABIT-1:0] res;
    logic                      sat_evt;
    logic                      out_valid_q, out_valid_d;
    logic signed [DATABIT-1:0] h_q, h_d;
    logic                      out_last_q, out_last_d;
    logic                      out_mode_q, out_mode_d;
    logic                      sat_q, sat_d;

    // S3 arithmetic: sum products, round half up, clamp to the signed result range
    always_comb begin
        sum     = WS'(s2_p1_q) + WS'(s2_p2_q) + WS'(s2_p3_q);
        rnd     = (sum + Half) >>> FRAC;
        sat_evt = 1'b0;
        res     = rnd[DATABIT-1:0];
        if (rnd > MaxV) begin
            res     = MaxV[DATABIT-1:0];
            sat_evt = 1'b1;
        end else if (rnd < MinV) begin
            res     = MinV[DATABIT-1:0];
            sat_evt = 1'b1;
        end
    end

    // Next state for counter, mode latch, all pipeline stages and the sticky flag
    always_comb begin
        adv       = ~out_valid_q | bus.out_ready;
        hs        = bus.in_valid & adv;
        // First element of a vector uses mode_i directly; the rest use the latched value.
        elem_mode = (cnt_q == '0) ? bus.mode_i : mode_q;

        cnt_d        = cnt_q;
        mode_d       = mode_q;
        s1_valid_d   = s1_valid_q;
        s1_last_d    = s1_last_q;
        s1_mode_d    = s1_mode_q;
        s1_z_d       = s1_z_q;
        s1_dz_d      = s1_dz_q;
        s1_h_prev_d  = s1_h_prev_q;
        s1_h_cand_d  = s1_h_cand_q;
        s1_dh_prev_d = s1_dh_prev_q;
        s1_dh_cand_d = s1_dh_cand_q;
        s1_diff_d    = s1_diff_q;
        s1_omz_d     = s1_omz_q;
        s2_valid_d   = s2_valid_q;
        s2_last_d    = s2_last_q;
        s2_mode_d    = s2_mode_q;
        s2_p1_d      = s2_p1_q;
        s2_p2_d      = s2_p2_q;
        s2_p3_d      = s2_p3_q;
        out_valid_d  = out_valid_q;
        h_d          = h_q;
        out_last_d   = out_last_q;
        out_mode_d   = out_mode_q;
        sat_d        = sat_q;

        if (hs) begin
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
            if (cnt_q == '0) begin
                mode_d = bus.mode_i;
            end
        end

        if (adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_last_d    = (cnt_q == LastCnt);
                s1_mode_d    = elem_mode;
                s1_z_d       = bus.z_i;
                s1_dz_d      = bus.dz_i;
                s1_h_prev_d  = bus.h_prev_i;
                s1_h_cand_d  = bus.h_cand_i;
                s1_dh_prev_d = bus.dh_prev_i;
                s1_dh_cand_d = bus.dh_cand_i;
                s1_diff_d    = W1'(bus.h_prev_i) - W1'(bus.h_cand_i);
                s1_omz_d     = One - W1'(bus.z_i);
            end

            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_last_d = s1_last_q;
                s2_mode_d = s1_mode_q;
                if (s1_mode_q) begin
                    s2_p1_d = WP'(s1_dz_q) * WP'(s1_diff_q);
                    s2_p2_d = WP'(s1_z_q) * WP'(s1_dh_prev_q);
                    s2_p3_d = WP'(s1_omz_q) * WP'(s1_dh_cand_q);
                end else begin
                    s2_p1_d = WP'(s1_z_q) * WP'(s1_h_prev_q);
                    s2_p2_d = WP'(s1_omz_q) * WP'(s1_h_cand_q);
                    s2_p3_d = '0;
                end
            end

            out_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                h_d        = res;
                out_last_d = s2_last_q;
                out_mode_d = s2_mode_q;
            end
        end

        // Set takes priority over a same-cycle clear.
        if (bus.sat_clr) begin
            sat_d = 1'b0;
        end
        if (adv && s2_valid_q && sat_evt) begin
            sat_d = 1'b1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            mode_q       <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_mode_q    <= 1'b0;
            s1_z_q       <= '0;
            s1_dz_q      <= '0;
            s1_h_prev_q  <= '0;
            s1_h_cand_q  <= '0;
            s1_dh_prev_q <= '0;
            s1_dh_cand_q <= '0;
            s1_diff_q    <= '0;
            s1_omz_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_mode_q    <= 1'b0;
            s2_p1_q      <= '0;
            s2_p2_q      <= '0;
            s2_p3_q      <= '0;
            out_valid_q  <= 1'b0;
            h_q          <= '0;
            out_last_q   <= 1'b0;
            out_mode_q   <= 1'b0;
            sat_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            s1_valid_q   <= s1_valid_d;
            s1_last_q    <= s1_last_d;
            s1_mode_q    <= s1_mode_d;
            s1_z_q       <= s1_z_d;
            s1_dz_q      <= s1_dz_d;
            s1_h_prev_q  <= s1_h_prev_d;
            s1_h_cand_q  <= s1_h_cand_d;
            s1_dh_prev_q <= s1_dh_prev_d;
            s1_dh_cand_q <= s1_dh_cand_d;
            s1_diff_q    <= s1_diff_d;
            s1_omz_q     <= s1_omz_d;
            s2_valid_q   <= s2_valid_d;
            s2_last_q    <= s2_last_d;
            s2_mode_q    <= s2_mode_d;
            s2_p1_q      <= s2_p1_d;
            s2_p2_q      <= s2_p2_d;
            s2_p3_q      <= s2_p3_d;
            out_valid_q  <= out_valid_d;
            h_q          <= h_d;
            out_last_q   <= out_last_d;
            out_mode_q   <= out_mode_d;
            sat_q        <= sat_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.h_o       = h_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_mode  = out_mode_q;
    assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_gru_state_update.sv
// Randomised scoreboard bench for gru_state_update (DATABIT=16, FRAC=14, CH=4).
module tb_gru_state_update;
    localparam int DATABIT = 16;
    localparam int FRAC    = 14;
    localparam int CH      = 4;

    typedef struct {
        logic signed [15:0] h;
        logic               last;
        logic               mode;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gru_state_update_if #(.DATABIT(DATABIT)) bus ();

    gru_state_update #(
        .DATABIT(DATABIT),
        .FRAC   (FRAC),
        .CH     (CH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cnt_m = 0;
    logic mode_m = 1'b0;
    logic rand_ready = 1'b1;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer maths of the GRU update with round-half-up and clamp.
    function automatic longint ref_h(input logic m, input longint z, dz, hp, hc, dhp, dhc);
        longint one, s, r;
        one = longint'(1) << FRAC;
        if (!m) s = z * hp + (one - z) * hc;
        else    s = dz * (hp - hc) + z * dhp + (one - z) * dhc;
        r = (s + one / 2) >>> FRAC;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    function automatic int rnd_op();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 65535)) - 32768;
        return int'($urandom_range(0, 8000)) - 4000;
    endfunction

    function automatic int rnd_z();
        return int'($urandom_range(0, 16384));
    endfunction

    task automatic send(input logic m, input int z, dz, hp, hc, dhp, dhc);
        int   t;
        exp_t e;
        t             = 0;
        bus.in_valid  = 1'b1;
        bus.mode_i    = m;
        bus.z_i       = 16'(z);
        bus.dz_i      = 16'(dz);
        bus.h_prev_i  = 16'(hp);
        bus.h_cand_i  = 16'(hc);
        bus.dh_prev_i = 16'(dhp);
        bus.dh_cand_i = 16'(dhc);
        do begin
            @(negedge clk);
            t++;
        end while (!bus.in_ready && t < 100);
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", t);
        end else begin
            if (cnt_m == 0) mode_m = m;
            e.h    = 16'(ref_h(mode_m, z, dz, hp, hc, dhp, dhc));
            e.last = (cnt_m == CH - 1);
            e.mode = mode_m;
            sb.push_back(e);
            cnt_m = (cnt_m + 1) % CH;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d results pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Downstream readiness: random backpressure unless a test needs it steady.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every output handshake and checks stall stability.
    initial begin
        exp_t               e;
        logic               prev_stall;
        logic signed [15:0] prev_h;
        logic               prev_last, prev_mode;
        prev_stall = 1'b0;
        prev_h     = '0;
        prev_last  = 1'b0;
        prev_mode  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_out_valid", bus.out_valid, 1);
                    check("stall_h_o", bus.h_o, prev_h);
                    check("stall_out_last", bus.out_last, prev_last);
                    check("stall_out_mode", bus.out_mode, prev_mode);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_output: got h_o=%0d, expected no output",
                                 bus.h_o);
                    end else begin
                        e = sb.pop_front();
                        check("h_o", bus.h_o, e.h);
                        check("out_last", bus.out_last, e.last);
                        check("out_mode", bus.out_mode, e.mode);
                    end
                end
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_h     = bus.h_o;
                prev_last  = bus.out_last;
                prev_mode  = bus.out_mode;
            end
        end
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.mode_i    = 1'b0;
        bus.z_i       = '0;
        bus.dz_i      = '0;
        bus.h_prev_i  = '0;
        bus.h_cand_i  = '0;
        bus.dh_prev_i = '0;
        bus.dh_cand_i = '0;
        bus.sat_clr   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_h_o", bus.h_o, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_out_mode", bus.out_mode, 0);
        check("rst_sat_flag", bus.sat_flag, 0);
        check("rst_in_ready", bus.in_ready, 1);

        // Forward vector
        send(1'b0, 8192, 0, 16384, -16384, 0, 0);
        send(1'b0, 16384, 0, 4096, 1234, 0, 0);
        send(1'b0, 0, 0, 777, -5000, 0, 0);
        send(1'b0, rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
        drain();
        check("fwd_no_sat", bus.sat_flag, 0);

        // Tangent vector including the half-up rounding case
        send(1'b1, 0, 16384, 8192, 0, 9999, 4096);
        send(1'b1, 0, 3, 8192, 0, 0, 0);
        send(1'b1, rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
        send(1'b1, rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());

        // Saturating tangent vector
        send(1'b1, 0, 32767, 32767, -32768, 0, 0);
        send(1'b1, 0, -32768, 32767, -32768, 0, 0);
        send(1'b1, rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
        send(1'b1, rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
        drain();
        check("sat_flag_set", bus.sat_flag, 1);

        // Plain clear, then a clear coinciding with a new sat event
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.sat_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.sat_clr = 1'b0;
        check("sat_flag_cleared", bus.sat_flag, 0);
        send(1'b1, 0, 32767, 32767, -32768, 0, 0);
        @(posedge clk);
        #1;
        bus.sat_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.sat_clr = 1'b0;
        check("sat_set_beats_clr", bus.sat_flag, 1);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
        end
        drain();
        rand_ready = 1'b1;

        // Mode latch: mode_i flips on element 2, takes effect on the next vector
        for (int i = 0; i < 8; i++) begin
            send(i >= 2, rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
        end

        // Random stream under random backpressure
        for (int i = 0; i < 12; i++) begin
            send(1'($urandom_range(0, 1)), rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(),
                 rnd_op());
        end
        drain();

        // Reset with two elements in flight
        send(1'b1, rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
        send(1'b1, rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        cnt_m = 0;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_h_o", bus.h_o, 0);
        check("mid_rst_out_mode", bus.out_mode, 0);
        check("mid_rst_sat_flag", bus.sat_flag, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            send(1'b0, rnd_z(), rnd_op(), rnd_op(), rnd_op(), rnd_op(), rnd_op());
        end
        drain();
        check("final_scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
